// File: rtl/sw_pkg.sv
// rtl/sw_pkg.sv - shared types and constants for the Smith-Waterman host sequencer
package sw_pkg;

    // Sequencer states.
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_T_RD,
        ST_T_SEND,
        ST_T_WAIT,
        ST_JOB_WAIT,
        ST_PARAM,
        ST_START,
        ST_STREAM,
        ST_RES_WAIT,
        ST_RES_OUT,
        ST_DONE
    } sw_state_e;

    // Field layout of the packed scoring parameter word.
    localparam int PARAM_MATCH_HI    = 23;
    localparam int PARAM_MATCH_LO    = 20;
    localparam int PARAM_MISMATCH_HI = 19;
    localparam int PARAM_MISMATCH_LO = 16;
    localparam int PARAM_ALPHA_HI    = 15;
    localparam int PARAM_ALPHA_LO    = 8;
    localparam int PARAM_BETA_HI     = 7;
    localparam int PARAM_BETA_LO     = 0;

    // Any non-zero value in this bit range marks the final T word.
    localparam int T_TERM_HI = 16;
    localparam int T_TERM_LO = 14;

    // Default core geometry.
    localparam int DEF_PE_ARRAY_SIZE     = 64;
    localparam int DEF_PE_ARRAY_SIZE_LOG = 6;
    localparam int DEF_RESULT_W          = 16;

    function automatic logic t_is_last(input logic [17:0] w);
        return |w[T_TERM_HI:T_TERM_LO];
    endfunction

endpackage

// File: rtl/sw_s_chunker.sv
// rtl/sw_s_chunker.sv - S chunk address/remaining counters and per-request valid count
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   i_load        load i_base / i_len as a new job
//   i_req         chunk request (already qualified by the sequencer state)
//   i_rdata       S memory read data (1-cycle latency from o_addr)
//   o_addr        registered S memory address of the next chunk
//   o_chunk       chunk data, valid while o_cnt != 0
//   o_cnt         registered valid-base count of the chunk, one-cycle pulse
//   o_last        a request now would drain the job
//   o_empty       no bases remain; a request now is an excess request
module sw_s_chunker
    import sw_pkg::*;
#(
    parameter int PE_ARRAY_SIZE     = DEF_PE_ARRAY_SIZE,
    parameter int PE_ARRAY_SIZE_LOG = DEF_PE_ARRAY_SIZE_LOG,
    parameter int S_ADDR_W          = 14,
    parameter int LEN_W             = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_load,
    input  logic [S_ADDR_W-1:0]          i_base,
    input  logic [LEN_W-1:0]             i_len,
    input  logic                         i_req,
    input  logic [2*PE_ARRAY_SIZE-1:0]   i_rdata,
    output logic [S_ADDR_W-1:0]          o_addr,
    output logic [2*PE_ARRAY_SIZE-1:0]   o_chunk,
    output logic [PE_ARRAY_SIZE_LOG:0]   o_cnt,
    output logic                         o_last,
    output logic                         o_empty
);

    localparam int CW = PE_ARRAY_SIZE_LOG + 1;
    localparam logic [LEN_W-1:0] PE_LEN = LEN_W'(PE_ARRAY_SIZE);
    localparam logic [CW-1:0]    PE_CNT = CW'(PE_ARRAY_SIZE);

    logic [S_ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]    rem_q,  rem_d;
    logic [CW-1:0]       cnt_q,  cnt_d;

    always_comb begin
        addr_d = addr_q;
        rem_d  = rem_q;
        cnt_d  = '0;
        if (i_load) begin
            addr_d = i_base;
            rem_d  = i_len;
        end else if (i_req && (rem_q != '0)) begin
            cnt_d  = (rem_q >= PE_LEN) ? PE_CNT : rem_q[CW-1:0];
            rem_d  = rem_q - LEN_W'(cnt_d);
            addr_d = addr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
            rem_q  <= '0;
            cnt_q  <= '0;
        end else begin
            addr_q <= addr_d;
            rem_q  <= rem_d;
            cnt_q  <= cnt_d;
        end
    end

    // The address is held for at least one cycle before each request and
    // advances on it, so the memory output register already holds the
    // requested chunk in the cycle after the request; it is passed through
    // gated by the registered count so excess requests present zero.
    assign o_addr  = addr_q;
    assign o_cnt   = cnt_q;
    assign o_chunk = (cnt_q != '0) ? i_rdata : '0;
    assign o_last  = (rem_q != '0) && (rem_q <= PE_LEN);
    assign o_empty = (rem_q == '0);

endmodule

// File: rtl/sw_host_seq.sv
// rtl/sw_host_seq.sv - host-side sequencer: T load, job queue, S streaming, result return
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   i_go                           start pulse (accepted in IDLE and DONE)
//   o_t_addr / i_t_rdata           T memory port, 1-cycle read latency
//   o_s_addr / i_s_rdata           S memory port, 1-cycle read latency
//   i_job_* / o_job_ready          job descriptor handshake
//   o_set_t, o_t                   T words to the core
//   o_param_valid, o_param         scoring parameters to the core
//   o_start_cal                    start pulse to the core
//   o_s, o_s_valid                 S chunk and its valid-base count
//   i_busy, i_request_s            core status / chunk request
//   i_result, i_valid              core score
//   o_res_valid/i_res_ready, o_res, o_res_id   tagged result handshake
//   o_done                         batch complete
//   o_err                          sticky: [0] T overflow, [1] excess S request
module sw_host_seq
    import sw_pkg::*;
#(
    parameter int PE_ARRAY_SIZE     = DEF_PE_ARRAY_SIZE,
    parameter int PE_ARRAY_SIZE_LOG = DEF_PE_ARRAY_SIZE_LOG,
    parameter int T_ADDR_W          = 10,
    parameter int S_ADDR_W          = 14,
    parameter int RESULT_W          = DEF_RESULT_W,
    parameter int JOB_ID_W          = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_go,
    output logic [T_ADDR_W-1:0]          o_t_addr,
    input  logic [17:0]                  i_t_rdata,
    output logic [S_ADDR_W-1:0]          o_s_addr,
    input  logic [2*PE_ARRAY_SIZE-1:0]   i_s_rdata,
    input  logic                         i_job_valid,
    output logic                         o_job_ready,
    input  logic [S_ADDR_W-1:0]          i_job_base,
    input  logic [15:0]                  i_job_len,
    input  logic [23:0]                  i_job_param,
    input  logic [JOB_ID_W-1:0]          i_job_id,
    input  logic                         i_job_last,
    output logic                         o_set_t,
    output logic [17:0]                  o_t,
    output logic                         o_param_valid,
    output logic [23:0]                  o_param,
    output logic                         o_start_cal,
    output logic [2*PE_ARRAY_SIZE-1:0]   o_s,
    output logic [PE_ARRAY_SIZE_LOG:0]   o_s_valid,
    input  logic                         i_busy,
    input  logic                         i_request_s,
    input  logic [RESULT_W-1:0]          i_result,
    input  logic                         i_valid,
    output logic                         o_res_valid,
    input  logic                         i_res_ready,
    output logic [RESULT_W-1:0]          o_res,
    output logic [JOB_ID_W-1:0]          o_res_id,
    output logic                         o_done,
    output logic [1:0]                   o_err
);

    sw_state_e             state_q, state_d;
    logic [T_ADDR_W-1:0]   t_addr_q, t_addr_d;
    logic [17:0]           t_q, t_d;
    logic                  set_t_q, set_t_d;
    logic                  param_valid_q, param_valid_d;
    logic [23:0]           param_q, param_d;
    logic                  start_q, start_d;
    logic                  job_ready_q, job_ready_d;
    logic                  res_valid_q, res_valid_d;
    logic [RESULT_W-1:0]   res_q, res_d;
    logic [JOB_ID_W-1:0]   res_id_q, res_id_d;
    logic [JOB_ID_W-1:0]   id_q, id_d;
    logic                  last_q, last_d;
    logic                  done_q, done_d;
    logic [1:0]            err_q, err_d;

    logic                  job_hs;
    logic                  chunk_req;
    logic                  chunk_last;
    logic                  chunk_empty;

    assign job_hs    = (state_q == ST_JOB_WAIT) && job_ready_q && i_job_valid;
    // Requests are honoured while streaming and, as excess requests, while
    // waiting for the score.
    assign chunk_req = i_request_s &&
                       ((state_q == ST_STREAM) || (state_q == ST_RES_WAIT));

    sw_s_chunker #(
        .PE_ARRAY_SIZE     (PE_ARRAY_SIZE),
        .PE_ARRAY_SIZE_LOG (PE_ARRAY_SIZE_LOG),
        .S_ADDR_W          (S_ADDR_W),
        .LEN_W             (16)
    ) u_chunker (
        .clk     (clk),
        .rst     (rst),
        .i_load  (job_hs),
        .i_base  (i_job_base),
        .i_len   (i_job_len),
        .i_req   (chunk_req),
        .i_rdata (i_s_rdata),
        .o_addr  (o_s_addr),
        .o_chunk (o_s),
        .o_cnt   (o_s_valid),
        .o_last  (chunk_last),
        .o_empty (chunk_empty)
    );

    always_comb begin
        state_d  = state_q;
        t_addr_d = t_addr_q;
        t_d      = '0;
        set_t_d  = 1'b0;
        param_d  = param_q;
        res_d    = res_q;
        res_id_d = res_id_q;
        id_d     = id_q;
        last_d   = last_q;
        err_d    = err_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (i_go) begin
                    state_d  = ST_T_RD;
                    t_addr_d = '0;
                    err_d    = 2'b00;
                end
            end
            ST_T_RD: begin
                // Address 0 is presented this cycle; keep the address one
                // ahead of the returning data from here on.
                state_d  = ST_T_SEND;
                t_addr_d = t_addr_q + 1'b1;
            end
            ST_T_SEND: begin
                // The word now on i_t_rdata is from address t_addr_q - 1, so
                // t_addr_q == 1 marks word 0 and t_addr_q == 0 marks the
                // last addressable word.
                t_d      = i_t_rdata;
                set_t_d  = (t_addr_q == T_ADDR_W'(1));
                t_addr_d = t_addr_q + 1'b1;
                if (t_is_last(i_t_rdata)) begin
                    state_d = ST_T_WAIT;
                end else if (t_addr_q == '0) begin
                    err_d[0] = 1'b1;
                    state_d  = ST_T_WAIT;
                end
            end
            ST_T_WAIT: begin
                if (!i_busy) begin
                    state_d = ST_JOB_WAIT;
                end
            end
            ST_JOB_WAIT: begin
                if (job_hs) begin
                    param_d = i_job_param;
                    id_d    = i_job_id;
                    last_d  = i_job_last;
                    state_d = ST_PARAM;
                end
            end
            ST_PARAM: state_d = ST_START;
            ST_START: state_d = ST_STREAM;
            ST_STREAM: begin
                if (chunk_req && chunk_last) begin
                    state_d = ST_RES_WAIT;
                end
            end
            ST_RES_WAIT: begin
                if (i_valid) begin
                    res_d    = i_result;
                    res_id_d = id_q;
                    state_d  = ST_RES_OUT;
                end
            end
            ST_RES_OUT: begin
                if (i_res_ready) begin
                    state_d = last_q ? ST_DONE : ST_JOB_WAIT;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (chunk_req && chunk_empty) begin
            err_d[1] = 1'b1;
        end

        // Level outputs are registered copies of the state being entered.
        job_ready_d   = (state_d == ST_JOB_WAIT);
        param_valid_d = (state_d == ST_PARAM);
        start_d       = (state_d == ST_START);
        res_valid_d   = (state_d == ST_RES_OUT);
        done_d        = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            t_addr_q      <= '0;
            t_q           <= '0;
            set_t_q       <= 1'b0;
            param_valid_q <= 1'b0;
            param_q       <= '0;
            start_q       <= 1'b0;
            job_ready_q   <= 1'b0;
            res_valid_q   <= 1'b0;
            res_q         <= '0;
            res_id_q      <= '0;
            id_q          <= '0;
            last_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 2'b00;
        end else begin
            state_q       <= state_d;
            t_addr_q      <= t_addr_d;
            t_q           <= t_d;
            set_t_q       <= set_t_d;
            param_valid_q <= param_valid_d;
            param_q       <= param_d;
            start_q       <= start_d;
            job_ready_q   <= job_ready_d;
            res_valid_q   <= res_valid_d;
            res_q         <= res_d;
            res_id_q      <= res_id_d;
            id_q          <= id_d;
            last_q        <= last_d;
            done_q        <= done_d;
            err_q         <= err_d;
        end
    end

    assign o_t_addr      = t_addr_q;
    assign o_t           = t_q;
    assign o_set_t       = set_t_q;
    assign o_param_valid = param_valid_q;
    assign o_param       = param_q;
    assign o_start_cal   = start_q;
    assign o_job_ready   = job_ready_q;
    assign o_res_valid   = res_valid_q;
    assign o_res         = res_q;
    assign o_res_id      = res_id_q;
    assign o_done        = done_q;
    assign o_err         = err_q;

endmodule

// File: tb/tb_sw_host_seq.sv
// tb/tb_sw_host_seq.sv - directed self-checking bench for sw_host_seq
module tb_sw_host_seq;

    localparam int PE   = 64;
    localparam int PEL  = 6;
    localparam int TAW  = 4;
    localparam int SAW  = 14;
    localparam int RW   = 16;
    localparam int IDW  = 4;

    logic             clk;
    logic             rst;
    logic             i_go;
    logic [TAW-1:0]   o_t_addr;
    logic [17:0]      t_rdata;
    logic [SAW-1:0]   o_s_addr;
    logic [2*PE-1:0]  s_rdata;
    logic             i_job_valid;
    logic             o_job_ready;
    logic [SAW-1:0]   i_job_base;
    logic [15:0]      i_job_len;
    logic [23:0]      i_job_param;
    logic [IDW-1:0]   i_job_id;
    logic             i_job_last;
    logic             o_set_t;
    logic [17:0]      o_t;
    logic             o_param_valid;
    logic [23:0]      o_param;
    logic             o_start_cal;
    logic [2*PE-1:0]  o_s;
    logic [PEL:0]     o_s_valid;
    logic             i_busy;
    logic             i_request_s;
    logic [RW-1:0]    i_result;
    logic             i_valid;
    logic             o_res_valid;
    logic             i_res_ready;
    logic [RW-1:0]    o_res;
    logic [IDW-1:0]   o_res_id;
    logic             o_done;
    logic [1:0]       o_err;

    logic [17:0]      tmem [0:15];
    logic [2*PE-1:0]  smem [0:15];

    int n_cmp = 0;
    int n_mis = 0;

    sw_host_seq #(
        .PE_ARRAY_SIZE     (PE),
        .PE_ARRAY_SIZE_LOG (PEL),
        .T_ADDR_W          (TAW),
        .S_ADDR_W          (SAW),
        .RESULT_W          (RW),
        .JOB_ID_W          (IDW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_go          (i_go),
        .o_t_addr      (o_t_addr),
        .i_t_rdata     (t_rdata),
        .o_s_addr      (o_s_addr),
        .i_s_rdata     (s_rdata),
        .i_job_valid   (i_job_valid),
        .o_job_ready   (o_job_ready),
        .i_job_base    (i_job_base),
        .i_job_len     (i_job_len),
        .i_job_param   (i_job_param),
        .i_job_id      (i_job_id),
        .i_job_last    (i_job_last),
        .o_set_t       (o_set_t),
        .o_t           (o_t),
        .o_param_valid (o_param_valid),
        .o_param       (o_param),
        .o_start_cal   (o_start_cal),
        .o_s           (o_s),
        .o_s_valid     (o_s_valid),
        .i_busy        (i_busy),
        .i_request_s   (i_request_s),
        .i_result      (i_result),
        .i_valid       (i_valid),
        .o_res_valid   (o_res_valid),
        .i_res_ready   (i_res_ready),
        .o_res         (o_res),
        .o_res_id      (o_res_id),
        .o_done        (o_done),
        .o_err         (o_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous-read memories, one cycle of latency.
    always @(posedge clk) begin
        t_rdata <= tmem[o_t_addr];
        s_rdata <= smem[o_s_addr[3:0]];
    end

    initial begin
        #400000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_t_addr"},  128'(o_t_addr), 128'd0);
        chk({tag, "_s_addr"},  128'(o_s_addr), 128'd0);
        chk({tag, "_set_t"},   128'(o_set_t), 128'd0);
        chk({tag, "_t"},       128'(o_t), 128'd0);
        chk({tag, "_pvalid"},  128'(o_param_valid), 128'd0);
        chk({tag, "_param"},   128'(o_param), 128'd0);
        chk({tag, "_start"},   128'(o_start_cal), 128'd0);
        chk({tag, "_s"},       o_s, 128'd0);
        chk({tag, "_s_valid"}, 128'(o_s_valid), 128'd0);
        chk({tag, "_jready"},  128'(o_job_ready), 128'd0);
        chk({tag, "_rvalid"},  128'(o_res_valid), 128'd0);
        chk({tag, "_res"},     128'(o_res), 128'd0);
        chk({tag, "_res_id"},  128'(o_res_id), 128'd0);
        chk({tag, "_done"},    128'(o_done), 128'd0);
        chk({tag, "_err"},     128'(o_err), 128'd0);
    endtask

    // Pulse i_go and check n T words starting two cycles later, then idle.
    task automatic t_load(input int n);
        i_go = 1'b1;
        @(negedge clk);
        i_go = 1'b0;
        chk("go_done_clr", 128'(o_done), 128'd0);
        chk("go_err_clr", 128'(o_err), 128'd0);
        @(negedge clk);
        chk("t_gap", 128'(o_t), 128'd0);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk($sformatf("t_word%0d", k), 128'(o_t), 128'(tmem[k]));
            chk($sformatf("set_t%0d", k), 128'(o_set_t), 128'(k == 0));
        end
        @(negedge clk);
        chk("t_end", 128'(o_t), 128'd0);
    endtask

    task automatic fill_t(input logic with_term);
        for (int k = 0; k < 16; k++) begin
            tmem[k] = 18'h00300 + 18'(k);
        end
        if (with_term) begin
            for (int k = 0; k < 5; k++) begin
                tmem[k] = 18'h00100 + 18'(k);
            end
            tmem[5] = 18'h04005;
        end
    endtask

    task automatic put_job(input logic [SAW-1:0] base, input logic [15:0] len,
                           input logic [23:0] prm, input logic [IDW-1:0] id,
                           input logic last);
        i_job_valid = 1'b1;
        i_job_base  = base;
        i_job_len   = len;
        i_job_param = prm;
        i_job_id    = id;
        i_job_last  = last;
    endtask

    int            lens  [3] = '{10, 65, 128};
    int            bases [3] = '{6, 7, 9};
    logic [RW-1:0] ress  [3] = '{16'h1234, 16'h0BCD, 16'hFFFF};
    int            rem;
    int            cnt;
    int            c;

    initial begin
        rst = 1'b1;
        i_go = 1'b0;
        i_job_valid = 1'b0;
        i_job_base = '0;
        i_job_len = '0;
        i_job_param = '0;
        i_job_id = '0;
        i_job_last = 1'b0;
        i_busy = 1'b1;
        i_request_s = 1'b0;
        i_result = '0;
        i_valid = 1'b0;
        i_res_ready = 1'b0;
        fill_t(1'b1);
        for (int i = 0; i < 16; i++) begin
            smem[i] = {8{16'(16'h1111 * (i + 1))}};
        end
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;

        // T load with terminator at word 5, busy released three cycles later.
        t_load(6);
        for (int k = 0; k < 3; k++) begin
            chk("busy_jready", 128'(o_job_ready), 128'd0);
            @(negedge clk);
        end
        i_busy = 1'b0;
        @(negedge clk);
        chk("jready_up", 128'(o_job_ready), 128'd1);
        chk("err_after_t", 128'(o_err), 128'd0);

        // Job 1: len 150 -> 64, 64, 22; a stray i_valid during START is ignored.
        put_job(14'd0, 16'd150, 24'h210301, 4'd3, 1'b0);
        @(negedge clk);
        chk("j1_pvalid", 128'(o_param_valid), 128'd1);
        chk("j1_param", 128'(o_param), 128'h210301);
        chk("j1_jready", 128'(o_job_ready), 128'd0);
        chk("j1_s_addr", 128'(o_s_addr), 128'd0);
        i_job_valid = 1'b0;
        @(negedge clk);
        chk("j1_start", 128'(o_start_cal), 128'd1);
        chk("j1_pvalid_off", 128'(o_param_valid), 128'd0);
        i_valid = 1'b1;
        i_result = 16'hBEEF;
        @(negedge clk);
        chk("j1_start_off", 128'(o_start_cal), 128'd0);
        i_valid = 1'b0;
        i_request_s = 1'b1;
        @(negedge clk);
        chk("j1_c0_cnt", 128'(o_s_valid), 128'd64);
        chk("j1_c0_s", o_s, smem[0]);
        @(negedge clk);
        chk("j1_c1_cnt", 128'(o_s_valid), 128'd64);
        chk("j1_c1_s", o_s, smem[1]);
        @(negedge clk);
        chk("j1_c2_cnt", 128'(o_s_valid), 128'd22);
        chk("j1_c2_s", o_s, smem[2]);
        i_request_s = 1'b0;
        @(negedge clk);
        chk("j1_s_idle", 128'(o_s_valid), 128'd0);
        chk("j1_s_zero", o_s, 128'd0);
        chk("j1_rvalid_wait", 128'(o_res_valid), 128'd0);
        i_valid = 1'b1;
        i_result = 16'h002A;
        @(negedge clk);
        i_valid = 1'b0;
        chk("j1_rvalid", 128'(o_res_valid), 128'd1);
        chk("j1_res", 128'(o_res), 128'h002A);
        chk("j1_res_id", 128'(o_res_id), 128'd3);
        chk("j1_err", 128'(o_err), 128'd0);

        // Result handshake with the next job already offered: 2-cycle turnaround.
        i_res_ready = 1'b1;
        put_job(14'd4, 16'd64, 24'h32_0502, 4'd5, 1'b0);
        @(negedge clk);
        i_res_ready = 1'b0;
        chk("j1_rvalid_off", 128'(o_res_valid), 128'd0);
        chk("turn_jready", 128'(o_job_ready), 128'd1);
        chk("turn_pvalid0", 128'(o_param_valid), 128'd0);
        @(negedge clk);
        chk("turn_pvalid1", 128'(o_param_valid), 128'd1);
        chk("j2_param", 128'(o_param), 128'h320502);
        i_job_valid = 1'b0;

        // Job 2: len 64, then an excess request.
        @(negedge clk);
        @(negedge clk);
        i_request_s = 1'b1;
        @(negedge clk);
        chk("j2_c0_cnt", 128'(o_s_valid), 128'd64);
        chk("j2_c0_s", o_s, smem[4]);
        @(negedge clk);
        i_request_s = 1'b0;
        chk("j2_excess_cnt", 128'(o_s_valid), 128'd0);
        chk("j2_excess_s", o_s, 128'd0);
        chk("j2_excess_err", 128'(o_err), 128'd2);
        i_valid = 1'b1;
        i_result = 16'h0155;
        @(negedge clk);
        i_valid = 1'b0;
        chk("j2_rvalid", 128'(o_res_valid), 128'd1);
        chk("j2_res", 128'(o_res), 128'h0155);
        chk("j2_res_id", 128'(o_res_id), 128'd5);
        i_res_ready = 1'b1;
        @(negedge clk);
        i_res_ready = 1'b0;
        chk("j2_rvalid_off", 128'(o_res_valid), 128'd0);
        chk("j2_jready", 128'(o_job_ready), 128'd1);
        chk("j2_err_sticky", 128'(o_err), 128'd2);

        // Three jobs, last on the third, each result held 5 cycles.
        for (int j = 0; j < 3; j++) begin
            chk($sformatf("b%0d_jready", j), 128'(o_job_ready), 128'd1);
            put_job(14'(bases[j]), 16'(lens[j]), 24'h110101 + 24'(j), 4'(7 + j), j == 2);
            @(negedge clk);
            chk($sformatf("b%0d_pvalid", j), 128'(o_param_valid), 128'd1);
            i_job_valid = 1'b0;
            @(negedge clk);
            @(negedge clk);
            rem = lens[j];
            c = 0;
            while (rem > 0) begin
                i_request_s = 1'b1;
                @(negedge clk);
                cnt = (rem >= PE) ? PE : rem;
                chk($sformatf("b%0d_c%0d_cnt", j, c), 128'(o_s_valid), 128'(cnt));
                chk($sformatf("b%0d_c%0d_s", j, c), o_s, smem[bases[j] + c]);
                rem = rem - cnt;
                c++;
            end
            i_request_s = 1'b0;
            i_valid = 1'b1;
            i_result = ress[j];
            @(negedge clk);
            i_valid = 1'b0;
            for (int h = 0; h < 5; h++) begin
                chk($sformatf("b%0d_hold%0d_v", j, h), 128'(o_res_valid), 128'd1);
                chk($sformatf("b%0d_hold%0d_r", j, h), 128'(o_res), 128'(ress[j]));
                chk($sformatf("b%0d_hold%0d_id", j, h), 128'(o_res_id), 128'(7 + j));
                @(negedge clk);
            end
            i_res_ready = 1'b1;
            @(negedge clk);
            i_res_ready = 1'b0;
            chk($sformatf("b%0d_rvalid_off", j), 128'(o_res_valid), 128'd0);
            chk($sformatf("b%0d_done", j), 128'(o_done), 128'(j == 2));
        end
        @(negedge clk);
        chk("done_stays", 128'(o_done), 128'd1);
        chk("done_jready", 128'(o_job_ready), 128'd0);

        // No terminator: all 16 words sent, overflow flagged, then JOB_WAIT.
        fill_t(1'b0);
        t_load(16);
        chk("wrap_err", 128'(o_err), 128'd1);
        chk("wrap_jready", 128'(o_job_ready), 128'd1);
        chk("wrap_done", 128'(o_done), 128'd0);

        // Reset in the middle of streaming, then a clean replay.
        put_job(14'd0, 16'd150, 24'h210301, 4'd1, 1'b0);
        @(negedge clk);
        i_job_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        i_request_s = 1'b1;
        @(negedge clk);
        chk("mid_cnt", 128'(o_s_valid), 128'd64);
        rst = 1'b1;
        @(negedge clk);
        chk_all_zero("mid_rst");
        rst = 1'b0;
        i_request_s = 1'b0;
        i_busy = 1'b1;
        fill_t(1'b1);
        t_load(6);
        i_busy = 1'b0;
        @(negedge clk);
        chk("replay_jready", 128'(o_job_ready), 128'd1);
        chk("replay_err", 128'(o_err), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
